// File: rtl/dm_cache_ctrl.sv
// Write-back, write-allocate controller for a direct-mapped cache with external tag/data arrays.
// Optional hit/miss statistics counters are built when DM_CACHE_STATS_EN is defined.
module dm_cache_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 10,
  parameter int LINE_W  = 128,
  parameter int WORD_W  = 32,
  parameter int TAG_W   = ADDR_W - INDEX_W - 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpu_req_valid,
  input  logic                 cpu_req_rw,
  input  logic [ADDR_W-1:0]    cpu_req_addr,
  input  logic [WORD_W-1:0]    cpu_req_data,
  output logic                 cpu_res_ready,
  output logic [WORD_W-1:0]    cpu_res_data,
  output logic                 mem_req_valid,
  output logic                 mem_req_rw,
  output logic [ADDR_W-1:0]    mem_req_addr,
  output logic [LINE_W-1:0]    mem_req_data,
  input  logic                 mem_res_ready,
  input  logic [LINE_W-1:0]    mem_res_data,
  output logic [INDEX_W-1:0]   arr_index,
  output logic                 tag_we,
  output logic [TAG_W+1:0]     tag_wdata,
  input  logic [TAG_W+1:0]     tag_rdata,
  output logic                 data_we,
  output logic [LINE_W-1:0]    data_wdata,
  input  logic [LINE_W-1:0]    data_rdata
`ifdef DM_CACHE_STATS_EN
  ,
  output logic [31:0]          hit_cnt,
  output logic [31:0]          miss_cnt
`endif
);

  typedef enum logic [2:0] {
    S_INIT       = 3'd0,
    S_IDLE       = 3'd1,
    S_COMPARE    = 3'd2,
    S_WRITE_BACK = 3'd3,
    S_ALLOCATE   = 3'd4
  } state_t;

  state_t               state, state_nxt;
  logic [INDEX_W-1:0]   init_cnt;
  logic                 req_rw;
  logic [ADDR_W-1:0]    req_addr;
  logic [WORD_W-1:0]    req_data;

  logic [INDEX_W-1:0]   req_index;
  logic [TAG_W-1:0]     req_tag;
  logic [1:0]           word_sel;
  logic                 rd_valid, rd_dirty, hit;
  logic [TAG_W-1:0]     rd_tag;
  logic                 unused_addr_lsb;

  assign req_index = req_addr[INDEX_W+3:4];
  assign req_tag   = req_addr[ADDR_W-1:INDEX_W+4];
  assign word_sel  = req_addr[3:2];
  assign rd_valid  = tag_rdata[TAG_W+1];
  assign rd_dirty  = tag_rdata[TAG_W];
  assign rd_tag    = tag_rdata[TAG_W-1:0];
  assign hit       = rd_valid && (rd_tag == req_tag);
  assign unused_addr_lsb = ^req_addr[1:0];

  function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0] line,
                                                   input logic [1:0]        sel,
                                                   input logic [WORD_W-1:0] word);
    logic [LINE_W-1:0] r;
    r = line;
    r[sel*WORD_W +: WORD_W] = word;
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_INIT;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_INIT) init_cnt <= init_cnt + 1'b1;
    end
  end

  // Request fields are only meaningful after IDLE has captured them.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && cpu_req_valid) begin
      req_rw   <= cpu_req_rw;
      req_addr <= cpu_req_addr;
      req_data <= cpu_req_data;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:       if (init_cnt == {INDEX_W{1'b1}}) state_nxt = S_IDLE;
      S_IDLE:       if (cpu_req_valid) state_nxt = S_COMPARE;
      S_COMPARE: begin
        if (hit)                       state_nxt = S_IDLE;
        else if (rd_valid && rd_dirty) state_nxt = S_WRITE_BACK;
        else                           state_nxt = S_ALLOCATE;
      end
      S_WRITE_BACK: if (mem_res_ready) state_nxt = S_ALLOCATE;
      S_ALLOCATE:   if (mem_res_ready) state_nxt = S_COMPARE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  // Outputs are forced low while reset is held so an in-flight memory request drops at once.
  always_comb begin
    cpu_res_ready = 1'b0;
    cpu_res_data  = '0;
    mem_req_valid = 1'b0;
    mem_req_rw    = 1'b0;
    mem_req_addr  = '0;
    mem_req_data  = '0;
    arr_index     = '0;
    tag_we        = 1'b0;
    tag_wdata     = '0;
    data_we       = 1'b0;
    data_wdata    = '0;
    if (rst_n) begin
      case (state)
        S_INIT: begin
          arr_index = init_cnt;
          tag_we    = 1'b1;
        end
        S_COMPARE: begin
          arr_index = req_index;
          if (hit) begin
            cpu_res_ready = 1'b1;
            cpu_res_data  = data_rdata[word_sel*WORD_W +: WORD_W];
            if (req_rw) begin
              data_we    = 1'b1;
              data_wdata = merge_word(data_rdata, word_sel, req_data);
              tag_we     = 1'b1;
              tag_wdata  = {1'b1, 1'b1, req_tag};
            end
          end
        end
        S_WRITE_BACK: begin
          arr_index     = req_index;
          mem_req_valid = 1'b1;
          mem_req_rw    = 1'b1;
          mem_req_addr  = {rd_tag, req_index, 4'b0000};
          mem_req_data  = data_rdata;
        end
        S_ALLOCATE: begin
          arr_index     = req_index;
          mem_req_valid = 1'b1;
          mem_req_addr  = {req_tag, req_index, 4'b0000};
          if (mem_res_ready) begin
            data_we    = 1'b1;
            data_wdata = mem_res_data;
            tag_we     = 1'b1;
            tag_wdata  = {1'b1, 1'b0, req_tag};
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DM_CACHE_STATS_EN
  // The COMPARE that follows a refill is a guaranteed hit and must not be counted again.
  logic refilled;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      refilled <= 1'b0;
    end else begin
      if (state == S_ALLOCATE && mem_res_ready) refilled <= 1'b1;
      else if (state == S_IDLE)                 refilled <= 1'b0;
      if (state == S_COMPARE && !refilled) begin
        if (hit) hit_cnt  <= hit_cnt + 32'd1;
        else     miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Randomized bench for dm_cache_ctrl against a word-level coherent memory model.
// Build with DM_CACHE_STATS_EN defined to also cover the hit/miss counters.
module tb_dm_cache_ctrl;
  localparam int ADDR_W = 32, INDEX_W = 10, LINE_W = 128, WORD_W = 32, TAG_W = 18;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cpu_req_valid, cpu_req_rw;
  logic [ADDR_W-1:0] cpu_req_addr;
  logic [WORD_W-1:0] cpu_req_data;
  logic cpu_res_ready;
  logic [WORD_W-1:0] cpu_res_data;
  logic mem_req_valid, mem_req_rw;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [LINE_W-1:0] mem_req_data;
  logic mem_res_ready;
  logic [LINE_W-1:0] mem_res_data;
  logic [INDEX_W-1:0] arr_index;
  logic tag_we, data_we;
  logic [TAG_W+1:0] tag_wdata, tag_rdata;
  logic [LINE_W-1:0] data_wdata, data_rdata;
`ifdef DM_CACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
  int exp_hits = 0, exp_misses = 0;
`endif

  int n_checks = 0, n_errors = 0;

  always #5 clk = ~clk;

  dm_cache_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_rw(cpu_req_rw),
    .cpu_req_addr(cpu_req_addr), .cpu_req_data(cpu_req_data),
    .cpu_res_ready(cpu_res_ready), .cpu_res_data(cpu_res_data),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_res_ready(mem_res_ready), .mem_res_data(mem_res_data),
    .arr_index(arr_index), .tag_we(tag_we), .tag_wdata(tag_wdata),
    .tag_rdata(tag_rdata), .data_we(data_we), .data_wdata(data_wdata),
    .data_rdata(data_rdata)
`ifdef DM_CACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  // Tag and data arrays: combinational read, write on clk.
  logic [TAG_W+1:0]  tag_mem  [0:1023];
  logic [LINE_W-1:0] data_mem [0:1023];
  assign tag_rdata  = tag_mem[arr_index];
  assign data_rdata = data_mem[arr_index];
  always @(posedge clk) begin
    if (tag_we)  tag_mem[arr_index]  <= tag_wdata;
    if (data_we) data_mem[arr_index] <= data_wdata;
  end

  // Reference: cache directory state plus the latest value of every written word.
  logic             ref_valid [0:1023];
  logic             ref_dirty [0:1023];
  logic [TAG_W-1:0] ref_tag   [0:1023];
  logic [31:0]  shadow [logic [31:0]];
  logic [127:0] mm     [logic [31:0]];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0FFEE11;
  endfunction

  function automatic logic [31:0] coh_word(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : init_word(a);
  endfunction

  function automatic logic [127:0] coh_line(input logic [31:0] la);
    return {coh_word(la + 32'd12), coh_word(la + 32'd8), coh_word(la + 32'd4), coh_word(la)};
  endfunction

  function automatic logic [127:0] mm_line(input logic [31:0] la);
    if (mm.exists(la)) return mm[la];
    return {init_word(la + 32'd12), init_word(la + 32'd8), init_word(la + 32'd4), init_word(la)};
  endfunction

  task automatic check_init();
    int bad = 0;
    int nz = 0;
    #1;
    for (int i = 0; i < 1024; i++) begin
      if (i > 0) @(negedge clk);
      if (tag_we !== 1'b1 || arr_index !== i[9:0] || tag_wdata !== '0 ||
          cpu_res_ready !== 1'b0 || mem_req_valid !== 1'b0) bad++;
    end
    chk("init_seq", 128'(bad), 128'(0));
    @(negedge clk);
    chk("idle_after_init", 128'(tag_we), 128'(0));
    for (int i = 0; i < 1024; i++) if (tag_mem[i] !== '0) nz++;
    chk("tags_cleared", 128'(nz), 128'(0));
    for (int i = 0; i < 1024; i++) begin
      ref_valid[i] = 1'b0;
      ref_dirty[i] = 1'b0;
      ref_tag[i]   = '0;
    end
  endtask

  task automatic do_req(input logic rw, input logic [31:0] addr, input logic [31:0] wd);
    logic [9:0] idx;
    logic [17:0] tg;
    logic hit, wb_exp;
    logic [31:0] wa, la, vla, rd_exp;
    logic [127:0] wb_line;
    int n, pulse_n;
    bit got, wb_seen, fetch_seen;
    wa = {addr[31:2], 2'b00};
    la = {addr[31:4], 4'b0000};
    idx = addr[13:4];
    tg = addr[31:14];
    hit = ref_valid[idx] && ref_tag[idx] == tg;
    wb_exp = !hit && ref_valid[idx] && ref_dirty[idx];
    vla = {ref_tag[idx], idx, 4'b0000};
    wb_line = coh_line(vla);
    rd_exp = coh_word(wa);
`ifdef DM_CACHE_STATS_EN
    if (hit) exp_hits++; else exp_misses++;
`endif
    cpu_req_valid = 1'b1; cpu_req_rw = rw; cpu_req_addr = addr; cpu_req_data = wd;
    n = 0; pulse_n = -10; got = 0; wb_seen = 0; fetch_seen = 0;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      mem_res_ready = 1'b0;
      if (cpu_res_ready) begin
        got = 1;
        cpu_req_valid = 1'b0;
        chk("res_no_memreq", 128'(mem_req_valid), 128'(0));
        if (!rw) chk("rd_data", 128'(cpu_res_data), 128'(rd_exp));
        chk("latency", 128'(n), 128'(hit ? 1 : pulse_n + 1));
        chk("wb_seen", 128'(wb_seen), 128'(wb_exp));
        chk("fetch_seen", 128'(fetch_seen), 128'(!hit));
      end else if (mem_req_valid && $urandom_range(0, 2) == 0) begin
        mem_res_ready = 1'b1;
        pulse_n = n;
        if (mem_req_rw) begin
          wb_seen = 1;
          chk("wb_addr", 128'(mem_req_addr), 128'(vla));
          chk("wb_data", mem_req_data, wb_line);
          mm[mem_req_addr] = mem_req_data;
        end else begin
          fetch_seen = 1;
          chk("fetch_addr", 128'(mem_req_addr), 128'(la));
          mem_res_data = mm_line(la);
        end
      end
    end
    if (!got) begin
      chk("timeout", 128'(0), 128'(1));
      cpu_req_valid = 1'b0;
    end
    ref_dirty[idx] = (hit ? ref_dirty[idx] : 1'b0) | rw;
    ref_valid[idx] = 1'b1;
    ref_tag[idx] = tg;
    if (rw) shadow[wa] = wd;
    // Idle cycle; a stray mem_res_ready here must be ignored.
    @(negedge clk);
    mem_res_ready = 1'(($urandom_range(0, 1)));
    mem_res_data = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    int n;
    logic [31:0] a;
    for (int i = 0; i < 1024; i++) begin
      tag_mem[i]  = 20'($urandom);
      data_mem[i] = {$urandom, $urandom, $urandom, $urandom};
    end
    cpu_req_valid = 1'b0; cpu_req_rw = 1'b0; cpu_req_addr = '0; cpu_req_data = '0;
    mem_res_ready = 1'b0; mem_res_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_tag_we", 128'(tag_we), 128'(0));
    chk("rst_mem_req", 128'(mem_req_valid), 128'(0));
    chk("rst_cpu_res", 128'(cpu_res_ready), 128'(0));
    rst_n = 1'b1;
    check_init();

    // Reset while a refill is outstanding.
    cpu_req_valid = 1'b1; cpu_req_rw = 1'b0; cpu_req_addr = 32'h0000_5670;
    n = 0;
    while (!mem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("alloc_reached", 128'(mem_req_valid && !mem_req_rw), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_async_mem_req", 128'(mem_req_valid), 128'(0));
    cpu_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_init();

    do_req(1'b0, 32'h0000_1234, 32'h0);
    chk("tag_after_fill", 128'(tag_mem[10'h123]), 128'(20'h80000));
    do_req(1'b1, 32'h0000_1234, 32'hDEADBEEF);
    chk("tag_after_write", 128'(tag_mem[10'h123]), 128'(20'hC0000));
    chk("line_after_write", data_mem[10'h123], coh_line(32'h0000_1230));
    do_req(1'b0, 32'h0001_1230, 32'h0);
    chk("tag_after_evict", 128'(tag_mem[10'h123]), 128'(20'h80004));
`ifdef DM_CACHE_STATS_EN
    chk("hit_cnt_directed", 128'(hit_cnt), 128'(1));
    chk("miss_cnt_directed", 128'(miss_cnt), 128'(2));
`endif

    for (int k = 0; k < 400; k++) begin
      a = {14'($urandom_range(0, 3)), 4'b0000, 10'($urandom_range(10'h120, 10'h124)),
           2'($urandom_range(0, 3)), 2'b00};
      do_req(1'($urandom_range(0, 1)), a, $urandom);
    end
`ifdef DM_CACHE_STATS_EN
    chk("hit_cnt_final", 128'(hit_cnt), 128'(exp_hits));
    chk("miss_cnt_final", 128'(miss_cnt), 128'(exp_misses));
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
